// File: rtl/fma16.sv
// Combinational binary16 fused multiply-add: +/-(x*y) +/- z with a single final rounding.
// Only the sticky exception-flag register is clocked.
module fma16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  sticky_flags
);

  // Every finite product and addend is an exact integer multiple of 2^-48 and
  // stays below 2^81, so the whole sum is formed exactly in one fixed-point word.
  localparam int MW = 82;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [1:0]  RM_RZ = 2'b00;
  localparam logic [1:0]  RM_RNE = 2'b01;
  localparam logic [1:0]  RM_RM = 2'b10;

  function automatic logic round_up(input logic [1:0] rm, input logic sgn,
                                    input logic lsb, input logic g, input logic s);
    case (rm)
      RM_RZ:   round_up = 1'b0;
      RM_RNE:  round_up = g & (s | lsb);
      RM_RM:   round_up = sgn & (g | s);
      default: round_up = ~sgn & (g | s);
    endcase
  endfunction

  // ---------------- operand classification ----------------
  logic [15:0] yv;
  assign yv = mul ? y : 16'h3C00;

  logic x_emax, y_emax, z_emax;
  logic x_nan, y_nan, z_nan, x_snan, y_snan, z_snan;
  logic x_inf, y_inf, z_inf, x_zero, y_zero;

  assign x_emax = &x[14:10];
  assign y_emax = &yv[14:10];
  assign z_emax = &z[14:10];

  assign x_nan  = x_emax & (|x[9:0]);
  assign y_nan  = y_emax & (|yv[9:0]);
  assign z_nan  = z_emax & (|z[9:0]) & add;
  assign x_snan = x_nan & ~x[9];
  assign y_snan = y_nan & ~yv[9];
  assign z_snan = z_nan & ~z[9];

  assign x_inf  = x_emax & ~(|x[9:0]);
  assign y_inf  = y_emax & ~(|yv[9:0]);
  assign z_inf  = z_emax & ~(|z[9:0]) & add;
  assign x_zero = ~(|x[14:0]);
  assign y_zero = ~(|yv[14:0]);

  logic sp, sz;
  assign sp = negp ^ x[15] ^ yv[15];
  assign sz = add ? (negz ^ z[15]) : sp;

  // ---------------- significands and effective exponents ----------------
  logic [10:0] x_sig, y_sig, z_sig;
  logic [4:0]  x_ee, y_ee, z_ee;

  assign x_sig = {|x[14:10], x[9:0]};
  assign y_sig = {|yv[14:10], yv[9:0]};
  assign z_sig = {|z[14:10], z[9:0]};
  assign x_ee  = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
  assign y_ee  = (yv[14:10] == 5'd0) ? 5'd1 : yv[14:10];
  assign z_ee  = (z[14:10] == 5'd0) ? 5'd1 : z[14:10];

  logic [21:0]   prod;
  logic [6:0]    pshift, zshift;
  logic [MW-1:0] mp, mz;

  assign prod   = 22'(x_sig) * 22'(y_sig);
  assign pshift = 7'(x_ee) + 7'(y_ee) - 7'd2;
  assign zshift = 7'(z_ee) + 7'd23;
  assign mp     = MW'(prod) << pshift;
  assign mz     = add ? (MW'(z_sig) << zshift) : '0;

  // ---------------- exact signed-magnitude sum ----------------
  logic [MW-1:0] mag;
  logic          rs;

  always_comb begin
    mag = '0;
    rs  = sp;
    if (sp == sz) begin
      mag = mp + mz;
      rs  = sp;
    end else if (mp > mz) begin
      mag = mp - mz;
      rs  = sp;
    end else if (mz > mp) begin
      mag = mz - mp;
      rs  = sz;
    end else begin
      mag = '0;
      rs  = (roundmode == RM_RM);
    end
  end

  logic [6:0] lead;
  always_comb begin
    lead = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead = 7'(i);
    end
  end

  // ---------------- rounding ----------------
  // Below 2^-14 the rounding position is pinned at 2^-24 (subnormal grid).
  logic [6:0]    lsb_pos;
  logic [10:0]   q;
  logic          guard, sticky, inc;
  logic [MW-1:0] below_mask;
  logic [17:0]   packed_res;

  assign lsb_pos    = (lead > 7'd33) ? (lead - 7'd10) : 7'd24;
  assign q          = 11'(mag >> lsb_pos);
  assign guard      = mag[lsb_pos - 7'd1];
  assign below_mask = (MW'(1) << (lsb_pos - 7'd1)) - MW'(1);
  assign sticky     = |(mag & below_mask);
  assign inc        = round_up(roundmode, rs, q[0], guard, sticky);

  // The hidden bit of q carries into the exponent field, so mantissa carry-out
  // and the subnormal-to-normal transition need no special handling.
  assign packed_res = (18'(lsb_pos - 7'd24) << 10) + 18'(q) + 18'(inc);

  logic ovf, inexact, tiny, unf, bump_at_33;

  assign ovf     = (packed_res >= 18'h07C00);
  assign inexact = guard | sticky;

  // Tininess after rounding: would rounding with an unbounded exponent
  // range still leave the value below 2^-14?
  assign bump_at_33 = (mag[33:23] == 11'h7FF) &
                      round_up(roundmode, rs, mag[23], mag[22], |mag[21:0]);
  assign tiny = (lead < 7'd33) | ((lead == 7'd33) & ~bump_at_33);
  assign unf  = tiny & inexact;

  logic [15:0] fin_result;
  logic [3:0]  fin_flags;

  always_comb begin
    fin_result = {rs, packed_res[14:0]};
    fin_flags  = {1'b0, 1'b0, unf, inexact};
    if (ovf) begin
      fin_flags = 4'b0101;
      case (roundmode)
        RM_RZ:   fin_result = {rs, 15'h7BFF};
        RM_RNE:  fin_result = {rs, 15'h7C00};
        RM_RM:   fin_result = rs ? 16'hFC00 : 16'h7BFF;
        default: fin_result = rs ? 16'hFBFF : 16'h7C00;
      endcase
    end
  end

  // ---------------- special operands ----------------
  logic any_nan, any_snan, prod_inf, prod_invalid, sum_invalid;

  assign any_nan      = x_nan | y_nan | z_nan;
  assign any_snan     = x_snan | y_snan | z_snan;
  assign prod_inf     = x_inf | y_inf;
  assign prod_invalid = (x_inf & y_zero) | (x_zero & y_inf);
  assign sum_invalid  = prod_inf & z_inf & (sp != sz);

  always_comb begin
    result = fin_result;
    flags  = fin_flags;
    if (any_nan) begin
      result = QNAN;
      flags  = {any_snan, 3'b000};
    end else if (prod_invalid | sum_invalid) begin
      result = QNAN;
      flags  = 4'b1000;
    end else if (prod_inf) begin
      result = {sp, 15'h7C00};
      flags  = 4'b0000;
    end else if (z_inf) begin
      result = {sz, 15'h7C00};
      flags  = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_flags <= 4'b0000;
    else       sticky_flags <= sticky_flags | flags;
  end

endmodule

// File: tb/tb_fma16.sv
// Directed-vector bench for fma16: hand-computed results/flags plus sticky-flag behaviour.
module tb_fma16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x = '0, y = '0, z = '0;
  logic        mul = 1'b1, add = 1'b0, negp = 1'b0, negz = 1'b0;
  logic [1:0]  roundmode = 2'b01;
  logic [15:0] result;
  logic [3:0]  flags, sticky_flags;

  int checks = 0;
  int failures = 0;

  fma16 dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .z(z), .mul(mul), .add(add),
    .negp(negp), .negz(negz), .roundmode(roundmode),
    .result(result), .flags(flags), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, b, c, input logic m, ad, np, nz,
                       input logic [1:0] rm);
    x = a; y = b; z = c; mul = m; add = ad; negp = np; negz = nz; roundmode = rm;
  endtask

  task automatic run(input string tag, input logic [15:0] a, b, c,
                     input logic m, ad, np, nz, input logic [1:0] rm,
                     input logic [15:0] exp_r, input logic [3:0] exp_f);
    @(posedge clk); #1;
    drive(a, b, c, m, ad, np, nz, rm);
    @(negedge clk);
    check({tag, "/res"}, result, exp_r);
    check({tag, "/flg"}, {12'h000, flags}, {12'h000, exp_f});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_sticky", {12'h000, sticky_flags}, 16'h0000);

    //   tag          x       y       z       mul   add   negp  negz  rm      result   flags
    run("mul",        16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000);
    run("add",        16'h3C00, 16'h7D00, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000);
    run("sub_zero",   16'h3C00, 16'h0000, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0000, 4'b0000);
    run("sub_zero_rm",16'h3C00, 16'h0000, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'h8000, 4'b0000);
    run("rnd_rne",    16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h3C02, 4'b0001);
    run("rnd_rp",     16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h3C03, 4'b0001);
    run("rnd_rz",     16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h3C02, 4'b0001);
    run("rnd_neg_rm", 16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 16'hBC03, 4'b0001);
    run("rnd_neg_rz", 16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'hBC02, 4'b0001);
    run("fma_tie",    16'h3C01, 16'h3C01, 16'hBC00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h1800, 4'b0001);
    run("fma_rp",     16'h3C01, 16'h3C01, 16'hBC00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h1801, 4'b0001);
    run("ovf_rne",    16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7C00, 4'b0101);
    run("ovf_rz",     16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h7BFF, 4'b0101);
    run("ovf_neg_rp", 16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 16'hFBFF, 4'b0101);
    run("ovf_neg_rm", 16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 16'hFC00, 4'b0101);
    run("inf_x_0",    16'h7C00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b1000);
    run("inf_m_inf",  16'h7C00, 16'h3C00, 16'h7C00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h7E00, 4'b1000);
    run("qnan_z",     16'h3C00, 16'h3C00, 16'h7E00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b0000);
    run("snan_x",     16'h7D00, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7E00, 4'b1000);
    run("snan_z_off", 16'h3C00, 16'h4000, 16'h7D00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000);
    run("inf_plus",   16'h7C00, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'hFC00, 4'b0000);
    run("neg_zero",   16'h8000, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h8000, 4'b0000);

    // clear the accumulated flags before the sticky sequence
    @(posedge clk); #1;
    drive(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("sticky_clr1", {12'h000, sticky_flags}, 16'h0000);

    run("sub_exact",  16'h0400, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0200, 4'b0000);
    run("sub_unf",    16'h0401, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0200, 4'b0011);
    run("ovf_again",  16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h7C00, 4'b0101);
    run("clean",      16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h4000, 4'b0000);
    @(posedge clk); #1;
    check("sticky_acc", {12'h000, sticky_flags}, 16'h0007);

    // reset together with a flagging operation: the clear must win
    drive(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
    check("sticky_clr2", {12'h000, sticky_flags}, 16'h0000);
    @(posedge clk); #1;
    check("sticky_hold", {12'h000, sticky_flags}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
